needle_gen: RTL and testbench

- Synchronous, multi-channel successor to the single-channel needle generator.
- Each channel turns a rising edge on an asynchronous input into an active-low "needle" pulse of programmable length in clk cycles. A per-channel gate qualifies the channel.
- Adds the following, none of which the previous generation had: input synchronisation, a programmable pulse width, a retrigger mode, and sticky missed-edge reporting.
- Sits between the trace/trigger inputs and the downstream strobe logic in the trc area.

---
 rtl/needle_pkg.sv | 12 +
 rtl/needle_gen_if.sv | 24 ++
 rtl/needle_chan.sv | 87 ++++++++
 rtl/needle_gen.sv | 32 +++
 tb/tb_needle_gen.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/needle_pkg.sv
// rtl/needle_pkg.sv - shared state encoding and constants for the needle generator
package needle_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    localparam int   MIN_WIDTH      = 1;
    localparam logic SYNC_RESET_VAL = 1'b1;

endpackage

// File: rtl/needle_gen_if.sv
// rtl/needle_gen_if.sv - trigger/gate inputs and needle/busy/missed outputs of the generator
interface needle_gen_if #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH_BITS = 8
);
    logic [CHANNELS-1:0]   in;
    logic [CHANNELS-1:0]   gate;
    logic [WIDTH_BITS-1:0] width;
    logic                  retrig;
    logic                  clr_missed;
    logic [CHANNELS-1:0]   needle;
    logic [CHANNELS-1:0]   busy;
    logic [CHANNELS-1:0]   missed;

    modport master (
        output in, gate, width, retrig, clr_missed,
        input  needle, busy, missed
    );

    modport slave (
        input  in, gate, width, retrig, clr_missed,
        output needle, busy, missed
    );
endinterface

// File: rtl/needle_chan.sv
// rtl/needle_chan.sv - one needle channel: synchroniser, edge detect, pulse FSM, missed flag
module needle_chan
    import needle_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in,
    input  logic                  gate,
    input  logic [WIDTH_BITS-1:0] width,
    input  logic                  retrig,
    input  logic                  clr_missed,
    output logic                  needle,
    output logic                  busy,
    output logic                  missed
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_det;
    logic                   miss_set;
    logic [WIDTH_BITS-1:0]  load_val;
    logic [WIDTH_BITS-1:0]  cnt;
    state_t                 state;

    // Sync and history flops reset high so a level already high at release is not an edge.
    assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign miss_set = (state == PULSE) & gate & edge_det & ~retrig;
    assign load_val = (width == '0) ? WIDTH_BITS'(MIN_WIDTH) : width;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{SYNC_RESET_VAL}};
            prev_q <= SYNC_RESET_VAL;
            state  <= IDLE;
            cnt    <= '0;
            needle <= 1'b1;
            busy   <= 1'b0;
            missed <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            prev_q <= sync_q[SYNC_STAGES-1];

            if (miss_set)
                missed <= 1'b1;
            else if (clr_missed)
                missed <= 1'b0;

            case (state)
                IDLE: begin
                    if (edge_det && gate) begin
                        cnt    <= load_val;
                        state  <= PULSE;
                        needle <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                PULSE: begin
                    if (!gate) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        needle <= 1'b1;
                        busy   <= 1'b0;
                    end else if (edge_det && retrig) begin
                        cnt <= load_val;
                    end else if (cnt <= WIDTH_BITS'(1)) begin
                        // Final cycle: counter stops at 1 and never wraps.
                        state  <= IDLE;
                        cnt    <= '0;
                        needle <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        cnt <= cnt - WIDTH_BITS'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    needle <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/needle_gen.sv
// rtl/needle_gen.sv - multi-channel needle pulse generator with shared width and mode controls
module needle_gen
    import needle_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH_BITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    needle_gen_if.slave bus
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        needle_chan #(
            .WIDTH_BITS (WIDTH_BITS),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .in        (bus.in[g]),
            .gate      (bus.gate[g]),
            .width     (bus.width),
            .retrig    (bus.retrig),
            .clr_missed(bus.clr_missed),
            .needle    (bus.needle[g]),
            .busy      (bus.busy[g]),
            .missed    (bus.missed[g])
        );
    end

endmodule

// File: tb/tb_needle_gen.sv
// tb/tb_needle_gen.sv - directed table-driven bench for needle_gen
module tb_needle_gen;

    localparam int CH = 4;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    needle_gen_if #(.CHANNELS(CH), .WIDTH_BITS(WB)) bus ();

    needle_gen #(
        .CHANNELS   (CH),
        .WIDTH_BITS (WB),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int w;
        bit r;
        int d;
        bit chg;
        int len;
        bit m;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Rising edge on channel 0 at cycle 0, dropped at cycle 2, optional re-rise at cycle d.
    task automatic run_vec(input vec_t v, input int idx);
        int  c;
        int  first;
        int  lows;
        int  bad;
        int  others;
        bit  done;
        c = 0; first = -1; lows = 0; bad = 0; others = 0; done = 0;
        bus.width  = WB'(v.w);
        bus.retrig = v.r;
        bus.gate   = 4'b0001;
        bus.in[0]  = 1'b1;
        while (!done && c < 600) begin
            step();
            c++;
            if (bus.needle[0] == 1'b0) begin
                if (first < 0) first = c;
                lows++;
            end else if (first >= 0) begin
                done = 1;
            end
            if (bus.busy[0] == bus.needle[0]) bad++;
            if (bus.needle[3:1] != 3'b111) others++;
            if (c == 2) bus.in[0] = 1'b0;
            if (v.d != 0 && c == v.d) bus.in[0] = 1'b1;
            if (v.chg && c == 5) bus.width = WB'(3);
        end
        check($sformatf("vec%0d_done", idx), int'(done), 1);
        check($sformatf("vec%0d_latency", idx), first, 3);
        check($sformatf("vec%0d_length", idx), lows, v.len);
        check($sformatf("vec%0d_missed", idx), int'(bus.missed[0]), int'(v.m));
        check($sformatf("vec%0d_busy_mirror", idx), bad, 0);
        check($sformatf("vec%0d_other_idle", idx), others, 0);
        bus.in[0]      = 1'b0;
        bus.clr_missed = 1'b1;
        step();
        bus.clr_missed = 1'b0;
        settle(4);
    endtask

    initial begin
        int c;
        int lows;
        int first4[CH];
        int lows4[CH];

        reset          = 1'b0;
        bus.in         = '0;
        bus.gate       = '0;
        bus.width      = '0;
        bus.retrig     = 1'b0;
        bus.clr_missed = 1'b0;
        #2 reset = 1'b1;
        #2;
        check("reset_needle", int'(bus.needle), 4'hF);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_missed", int'(bus.missed), 0);
        settle(3);
        reset = 1'b0;
        settle(3);

        vecs[0] = '{w: 5,   r: 0, d: 0, chg: 0, len: 5,   m: 0};
        vecs[1] = '{w: 0,   r: 0, d: 0, chg: 0, len: 1,   m: 0};
        vecs[2] = '{w: 255, r: 0, d: 0, chg: 1, len: 255, m: 0};
        vecs[3] = '{w: 8,   r: 1, d: 6, chg: 0, len: 14,  m: 0};
        vecs[4] = '{w: 8,   r: 1, d: 8, chg: 0, len: 16,  m: 0};
        vecs[5] = '{w: 8,   r: 0, d: 6, chg: 0, len: 8,   m: 1};
        vecs[6] = '{w: 8,   r: 0, d: 8, chg: 0, len: 8,   m: 1};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Missed set and clr_missed in the same cycle, then clr_missed alone.
        bus.width = WB'(8); bus.retrig = 1'b0; bus.gate = 4'b0001;
        bus.in[0] = 1'b1;
        for (c = 1; c <= 14; c++) begin
            step();
            if (c == 2) bus.in[0] = 1'b0;
            if (c == 6) bus.in[0] = 1'b1;
            if (c == 8) begin
                check("missed_before_set", int'(bus.missed[0]), 0);
                bus.clr_missed = 1'b1;
            end
            if (c == 9) begin
                check("missed_set_wins", int'(bus.missed[0]), 1);
                bus.clr_missed = 1'b0;
            end
            if (c == 12) bus.clr_missed = 1'b1;
            if (c == 13) begin
                check("missed_cleared", int'(bus.missed[0]), 0);
                bus.clr_missed = 1'b0;
            end
        end
        bus.in[0] = 1'b0;
        settle(4);

        // Edge with gate low: no pulse, no miss.
        bus.gate = '0;
        bus.in[0] = 1'b1;
        lows = 0;
        for (c = 1; c <= 8; c++) begin
            step();
            if (bus.needle[0] == 1'b0) lows++;
        end
        check("gate_off_no_pulse", lows, 0);
        check("gate_off_no_miss", int'(bus.missed[0]), 0);
        bus.in[0] = 1'b0;
        settle(4);

        // Gate dropped two cycles into an 8-cycle pulse.
        bus.gate = 4'b0001; bus.width = WB'(8);
        bus.in[0] = 1'b1;
        for (c = 1; c <= 5; c++) begin
            step();
            if (c == 2) bus.in[0] = 1'b0;
            if (c == 4) begin
                check("gate_drop_pre", int'(bus.needle[0]), 0);
                bus.gate = '0;
            end
            if (c == 5) begin
                check("gate_drop_needle", int'(bus.needle[0]), 1);
                check("gate_drop_busy", int'(bus.busy[0]), 0);
            end
        end
        settle(4);

        // Input held high through reset release must not trigger.
        reset = 1'b1;
        bus.in[1] = 1'b1;
        settle(2);
        reset = 1'b0;
        bus.gate = 4'hF; bus.width = WB'(4);
        lows = 0;
        for (c = 1; c <= 8; c++) begin
            step();
            if (bus.needle[1] == 1'b0) lows++;
        end
        check("high_at_release_no_pulse", lows, 0);
        bus.in = '0;
        settle(4);

        // Reset mid-pulse returns needle high without a clock edge.
        bus.gate = 4'b0001; bus.width = WB'(20);
        bus.in[0] = 1'b1;
        settle(5);
        check("pre_reset_low", int'(bus.needle[0]), 0);
        bus.in[0] = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_needle", int'(bus.needle), 4'hF);
        check("async_reset_busy", int'(bus.busy), 0);
        step();
        reset = 1'b0;
        settle(4);

        // All four channels edged together.
        bus.gate = 4'hF; bus.width = WB'(4);
        for (int k = 0; k < CH; k++) begin first4[k] = -1; lows4[k] = 0; end
        bus.in = 4'hF;
        for (c = 1; c <= 15; c++) begin
            step();
            for (int k = 0; k < CH; k++) begin
                if (bus.needle[k] == 1'b0) begin
                    if (first4[k] < 0) first4[k] = c;
                    lows4[k]++;
                end
            end
        end
        for (int k = 0; k < CH; k++) begin
            check($sformatf("multi_ch%0d_latency", k), first4[k], 3);
            check($sformatf("multi_ch%0d_length", k), lows4[k], 4);
        end
        bus.in = '0;
        settle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
